// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store size codes,
// FSM encoding and a log2 helper for sizing the word index.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Lane steering for one access: byte enables and replicated write word for stores,
// lane select plus sign/zero extension for loads, and the natural-alignment check.
module mem_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o,
  output logic        align_err_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword_i[{lane_i, 3'b000} +: 8];
  assign rhalf = lane_i[1] ? rword_i[31:16] : rword_i[15:0];

  // Write data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be_o        = 4'b0000;
    wword_o     = '0;
    rdata_o     = '0;
    align_err_o = 1'b0;
    case (funct3_i)
      F3_B, F3_BU: begin
        be_o    = 4'b0001 << lane_i;
        wword_o = {4{wdata_i[7:0]}};
        rdata_o = funct3_i[2] ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
      end
      F3_H, F3_HU: begin
        align_err_o = lane_i[0];
        be_o        = lane_i[1] ? 4'b1100 : 4'b0011;
        wword_o     = {2{wdata_i[15:0]}};
        rdata_o     = funct3_i[2] ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
      end
      F3_W: begin
        align_err_o = |lane_i;
        be_o        = 4'b1111;
        wword_o     = wdata_i;
        rdata_o     = rword_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Timed load/store target behind the MEM stage: one request per handshake, a fixed
// number of wait states, then a held response carrying load data or an error flag.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IW = clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [IW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   rword, wword, ld_data;
  logic [3:0]    be;
  logic          align_err, range_err, f3_err, acc_err;
  logic          accept, done;

  assign accept = (state_q == S_IDLE) && req_valid;
  assign done   = (state_q == S_WAIT) && (cnt_q == 4'(WAIT_CYCLES));

  assign idx   = addr_q[IW+1:2];
  assign lane  = addr_q[1:0];
  assign rword = mem_q[idx];

  // Stores only have B/H/W; loads additionally have BU/HU.
  assign range_err = |addr_q[31:IW+2];
  assign f3_err    = we_q ? (f3_q > F3_W) : ((f3_q == 3'b011) || (f3_q[2:1] == 2'b11));
  assign acc_err   = range_err | f3_err | align_err;

  mem_align u_align (
    .funct3_i    (f3_q),
    .lane_i      (lane),
    .wdata_i     (wdata_q),
    .rword_i     (rword),
    .be_o        (be),
    .wword_o     (wword),
    .rdata_o     (ld_data),
    .align_err_o (align_err)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = S_WAIT;
          cnt_d   = 4'd0;
        end
      end
      S_WAIT: begin
        if (done) state_d = S_RESP;
        else      cnt_d   = cnt_q + 4'd1;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (done) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || we_q) ? 32'h0 : ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Reset forces IDLE asynchronously, so an interrupted access can never reach done.
  always_ff @(posedge clk) begin
    if (done && we_q && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: two instances (2 and 0 wait states), expected
// responses queued at issue time and checked by an independent response monitor.
module tb_dmem_responder;

  typedef struct packed {
    logic        k;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  reset, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [31:0] rsp_rdata [2];

  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         acc_cyc [2];
  logic [1:0] seen = 2'b00;
  exp_t       exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: every cycle a response is presented it must match the queue head.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset[k] && rsp_valid[k]) begin
        if (!seen[k]) begin
          seen[k] = 1'b1;
          chk("latency", 32'(cyc - acc_cyc[k]), (k == 0) ? 32'd3 : 32'd1);
        end
        chk("req_ready_in_resp", 32'(req_ready[k]), 32'd0);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp dut%0d: got rdata 0x%08h err %0d expected none",
                   k, rsp_rdata[k], rsp_err[k]);
        end else begin
          chk("rsp_dut", 32'(k), 32'(exp_q[0].k));
          chk("rdata", rsp_rdata[k], exp_q[0].rdata);
          chk("err", 32'(rsp_err[k]), 32'(exp_q[0].err));
          if (rsp_ready[k]) begin
            void'(exp_q.pop_front());
            seen[k] = 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(input int k, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input bit push);
    int   n;
    exp_t e;
    @(negedge clk);
    req_valid[k]  = 1'b1;
    req_we[k]     = we;
    req_funct3[k] = f3;
    req_addr[k]   = a;
    req_wdata[k]  = wd;
    n = 0;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[k]) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout dut%0d: req_ready stuck at 0, expected 1", k);
      req_valid[k] = 1'b0;
      return;
    end
    if (push) begin
      e.k     = k[0];
      e.rdata = er;
      e.err   = ee;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    acc_cyc[k]   = cyc;
    req_valid[k] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic xfer(input int k, input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] er, input logic ee);
    issue(k, we, f3, a, wd, er, ee, 1'b1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset     = 2'b00;
    req_valid = 2'b00;
    req_we    = 2'b00;
    rsp_ready = 2'b11;
    for (int k = 0; k < 2; k++) begin
      req_funct3[k] = 3'b000;
      req_addr[k]   = '0;
      req_wdata[k]  = '0;
      acc_cyc[k]    = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      chk("rst_rdata", rsp_rdata[k], 32'd0);
      chk("rst_err", 32'(rsp_err[k]), 32'd0);
    end
    reset = 2'b11;
    @(negedge clk);
    chk("rst_req_ready0", 32'(req_ready[0]), 32'd1);
    chk("rst_req_ready1", 32'(req_ready[1]), 32'd1);

    // Basic word store/load
    xfer(0, 1'b1, W,  32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    xfer(0, 1'b0, W,  32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    // Byte and halfword lanes, extension
    xfer(0, 1'b1, B,  32'h11, 32'h0000_0080, 32'h0, 1'b0);
    xfer(0, 1'b0, B,  32'h11, 32'h0, 32'hFFFF_FF80, 1'b0);
    xfer(0, 1'b0, BU, 32'h11, 32'h0, 32'h0000_0080, 1'b0);
    xfer(0, 1'b0, W,  32'h10, 32'h0, 32'hDEAD_80EF, 1'b0);
    xfer(0, 1'b0, H,  32'h12, 32'h0, 32'hFFFF_DEAD, 1'b0);
    xfer(0, 1'b0, HU, 32'h12, 32'h0, 32'h0000_DEAD, 1'b0);
    xfer(0, 1'b1, H,  32'h12, 32'hAAAA_1234, 32'h0, 1'b0);
    xfer(0, 1'b0, W,  32'h10, 32'h0, 32'h1234_80EF, 1'b0);
    // Misalignment
    xfer(0, 1'b0, H,  32'h13, 32'h0, 32'h0, 1'b1);
    xfer(0, 1'b0, W,  32'h12, 32'h0, 32'h0, 1'b1);
    xfer(0, 1'b1, W,  32'h12, 32'h1234_5678, 32'h0, 1'b1);
    xfer(0, 1'b0, W,  32'h10, 32'h0, 32'h1234_80EF, 1'b0);
    // Range and illegal size codes
    xfer(0, 1'b0, W,  32'h1000, 32'h0, 32'h0, 1'b1);
    xfer(0, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    xfer(0, 1'b1, BU, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1);
    xfer(0, 1'b1, W,  32'hFFC, 32'h0BAD_F00D, 32'h0, 1'b0);
    xfer(0, 1'b0, W,  32'hFFC, 32'h0, 32'h0BAD_F00D, 1'b0);
    xfer(0, 1'b0, W,  32'h10, 32'h0, 32'h1234_80EF, 1'b0);

    // Back-pressure on the response channel; a new request must be ignored meanwhile
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, W, 32'h10, 32'h0, 32'h1234_80EF, 1'b0, 1'b1);
    n = 0;
    while (!rsp_valid[0] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("resp_reached", 32'(rsp_valid[0]), 32'd1);
    req_we[0]     = 1'b1;
    req_funct3[0] = W;
    req_addr[0]   = 32'h10;
    req_wdata[0]  = 32'h0;
    req_valid[0]  = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_after_rsp_ready", 32'(req_ready[0]), 32'd1);
    chk("rsp_valid_dropped", 32'(rsp_valid[0]), 32'd0);
    drain();
    xfer(0, 1'b0, W, 32'h10, 32'h0, 32'h1234_80EF, 1'b0);

    // Reset in the middle of a store's wait states
    xfer(0, 1'b1, W, 32'h20, 32'hCAFE_0000, 32'h0, 1'b0);
    xfer(0, 1'b0, W, 32'h10, 32'h0, 32'h1234_80EF, 1'b0);
    issue(0, 1'b1, W, 32'h20, 32'h0000_0001, 32'h0, 1'b0, 1'b0);
    #1;
    reset[0] = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("midrst_rdata", rsp_rdata[0], 32'd0);
    chk("midrst_err", 32'(rsp_err[0]), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_rsp_valid_held", 32'(rsp_valid[0]), 32'd0);
    @(negedge clk);
    reset[0] = 1'b1;
    @(negedge clk);
    chk("postrst_req_ready", 32'(req_ready[0]), 32'd1);
    xfer(0, 1'b0, W, 32'h20, 32'h0, 32'hCAFE_0000, 1'b0);

    // Zero wait states
    xfer(1, 1'b1, W, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    xfer(1, 1'b0, W, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    xfer(1, 1'b1, B, 32'h13, 32'h0000_0011, 32'h0, 1'b0);
    xfer(1, 1'b0, W, 32'h10, 32'h0, 32'h11AD_BEEF, 1'b0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
